pll_reconfig_ctrl: RTL and testbench
====================================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, PLL reset pulse length in clk cycles.
REQ-002 The block SHALL have parameter LOCK_STABLE, default 1024, consecutive synced-lock cycles required before lock is declared.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 65535, cycles allowed in WAIT_LOCK before a retry.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, consecutive timeouts before FAULT.
REQ-005 The block SHALL have parameters INIT_IDSEL, INIT_FBDSEL and INIT_ODSEL, each 6 bits, default 6'd0, divider selects applied after reset.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, free-running crystal clock (never PLL output); rst_n in 1, asynchronous active-low reset.
REQ-007 The block SHALL have the configuration-request ports: cfg_valid in 1, new-config request; cfg_ready out 1, request accepted this cycle when high with cfg_valid.
REQ-008 The block SHALL have the configuration-data ports: cfg_idsel in 6; cfg_fbdsel in 6; cfg_odsel in 6; all raw PLL dynamic-select codes, passed through unencoded.
REQ-009 The block SHALL have the PLL-control ports: pll_lock in 1, PLL LOCK, asynchronous to clk; pll_reset out 1, drives PLL RESET.
REQ-010 The block SHALL have the PLL divider-select outputs: pll_idsel out 6; pll_fbdsel out 6; pll_odsel out 6; drive IDSEL/FBDSEL/ODSEL.
REQ-011 The block SHALL have the status ports: locked out 1, stable lock; out_rst_n out 1, active-low reset for PLL-clocked logic; timeout_err out 1, sticky; fault out 1; lost_cnt out 8, lock-loss count.

Function
REQ-012 pll_lock SHALL pass through a 2-flop synchronizer; all decisions use the synced value (lock_s).
REQ-013 The FSM SHALL have states RESET_HOLD, WAIT_LOCK, STABLE_CHECK, RUN and FAULT.
REQ-014 In RESET_HOLD, pll_reset=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-015 In WAIT_LOCK, pll_reset=0: lock_s=1 -> STABLE_CHECK; timeout counter reaching LOCK_TIMEOUT -> retry.
REQ-016 On retry, timeout_err SHALL be set and retry_cnt incremented, then -> RESET_HOLD, or -> FAULT if retry_cnt reaches MAX_RETRY.
REQ-017 In STABLE_CHECK, lock_s must stay 1 for LOCK_STABLE consecutive cycles -> RUN; any lock_s=0 -> WAIT_LOCK with the stable counter cleared and the timeout counter restarted.
REQ-018 Entering RUN SHALL clear retry_cnt; locked=1 in RUN only.
REQ-019 out_rst_n SHALL be a register equal to (state==RUN) delayed one cycle, so it rises one cycle after locked and falls one cycle after leaving RUN.
REQ-020 In RUN, lock_s=0 -> RESET_HOLD, with lost_cnt incremented and saturating at 255.
REQ-021 cfg_ready SHALL be 1 only in RUN and FAULT; on cfg_valid&&cfg_ready the selects are latched into pll_*sel, timeout_err and retry_cnt are cleared, and the FSM goes -> RESET_HOLD next cycle.
REQ-022 If lock loss and cfg_valid occur in the same RUN cycle, the config SHALL be accepted and lost_cnt still incremented.
REQ-023 cfg_valid outside RUN/FAULT SHALL be ignored; no queuing.
REQ-024 pll_*sel SHALL change only on acceptance or reset, never while pll_reset=0 outside an acceptance.
REQ-025 FAULT SHALL hold pll_reset=1 and fault=1 until a config is accepted.

Reset
REQ-026 On rst_n=0, asynchronously: state=RESET_HOLD, pll_reset=1, pll_*sel=INIT_*, locked=0, out_rst_n=0, timeout_err=0, fault=0, lost_cnt=0, all counters 0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately; after release, a full RST_CYCLES pulse is reissued.

Structure
REQ-028 The FSM state enum and 6-bit select width constant SHALL live in shared package pll_ctrl_pkg.
REQ-029 The 2-flop synchronizer SHALL be sub-module sync_2ff, reused for other async status inputs.
REQ-030 The block SHALL instantiate no PLL primitive; the top level connects it to the Gowin_rPLL wrapper configured with DYN_*_SEL="true".

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2)
REQ-031 Release rst_n, raise pll_lock at cycle 10 -> pll_reset high cycles 1-4, locked=1 after 2 sync + 8 stable cycles, out_rst_n=1 one cycle later.
REQ-032 Glitch pll_lock low for 1 cycle at stable count 5 -> return to WAIT_LOCK; locked only after 8 fresh consecutive cycles.
REQ-033 Hold pll_lock=0 -> two 32-cycle timeouts, timeout_err=1, fault=1, pll_reset held high; cfg_valid with idsel=6'h3C -> pll_idsel=6'h3C, fault=0, new 4-cycle reset pulse.
REQ-034 In RUN, drop pll_lock -> locked=0 in 3 cycles, lost_cnt=1; repeat 300 times -> lost_cnt=255.
REQ-035 In RUN, cfg_valid with fbdsel=6'h2A -> cfg_ready=1 that cycle, pll_fbdsel=6'h2A, locked=0, out_rst_n=0 next cycle; cfg_valid during WAIT_LOCK -> no change.
REQ-036 Assert rst_n=0 during STABLE_CHECK -> all outputs at reset values same cycle, pll_reset=1.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration controller.
package pll_ctrl_pkg;

    // Width of the raw PLL IDSEL/FBDSEL/ODSEL dynamic-select codes.
    localparam int unsigned SEL_W = 6;

    typedef enum logic [2:0] {
        StResetHold   = 3'd0,
        StWaitLock    = 3'd1,
        StStableCheck = 3'd2,
        StRun         = 3'd3,
        StFault       = 3'd4
    } pll_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the async input through two flops; resets to deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer with dynamic divider reconfiguration. Runs from a
// free-running crystal clock; the PLL primitive itself lives outside this block.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned     RST_CYCLES   = 16,
    parameter int unsigned     LOCK_STABLE  = 1024,
    parameter int unsigned     LOCK_TIMEOUT = 65535,
    parameter int unsigned     MAX_RETRY    = 3,
    parameter logic [SEL_W-1:0] INIT_IDSEL  = 6'd0,
    parameter logic [SEL_W-1:0] INIT_FBDSEL = 6'd0,
    parameter logic [SEL_W-1:0] INIT_ODSEL  = 6'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             locked,
    output logic             out_rst_n,
    output logic             timeout_err,
    output logic             fault,
    output logic [7:0]       lost_cnt
);

    // One shared counter serves the reset pulse, lock timeout and stability
    // window; it is cleared on every state change so each phase starts at 0.
    localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 1);

    logic lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               terr_q, terr_d;
    logic [7:0]         lost_q, lost_d;
    logic [SEL_W-1:0]   idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic               pll_reset_q, locked_q, fault_q, cfg_ready_q, out_rst_n_q;
    logic               accept;

    assign accept    = cfg_valid && cfg_ready_q;
    assign retry_inc = retry_q + 1'b1;

    // Next-state logic; an accepted config overrides whatever the state decided.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        terr_d   = terr_q;
        lost_d   = lost_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;

        unique case (state_q)
            StResetHold: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStableCheck;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc >= RETRY_W'(MAX_RETRY)) ? StFault : StResetHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStableCheck: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    lost_d  = sat_inc8(lost_q);
                    state_d = StResetHold;
                    cnt_d   = '0;
                end
            end
            StFault: begin
                // Parked with the PLL held in reset until a new config arrives.
            end
            default: begin
                state_d = StResetHold;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
            terr_d   = 1'b0;
            retry_d  = '0;
            state_d  = StResetHold;
            cnt_d    = '0;
        end
    end

    // State, counters and registered outputs; outputs track the next state so
    // they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StResetHold;
            cnt_q       <= '0;
            retry_q     <= '0;
            terr_q      <= 1'b0;
            lost_q      <= 8'd0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
            cfg_ready_q <= 1'b0;
            out_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            terr_q      <= terr_d;
            lost_q      <= lost_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= (state_d == StResetHold) || (state_d == StFault);
            locked_q    <= (state_d == StRun);
            fault_q     <= (state_d == StFault);
            cfg_ready_q <= (state_d == StRun) || (state_d == StFault);
            // Deliberately one cycle behind RUN so PLL-clocked logic leaves
            // reset only after the clock has been declared stable.
            out_rst_n_q <= (state_q == StRun);
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign pll_reset   = pll_reset_q;
    assign pll_idsel   = idsel_q;
    assign pll_fbdsel  = fbdsel_q;
    assign pll_odsel   = odsel_q;
    assign locked      = locked_q;
    assign out_rst_n   = out_rst_n_q;
    assign timeout_err = terr_q;
    assign fault       = fault_q;
    assign lost_cnt    = lost_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed self-checking bench for pll_reconfig_ctrl (short timing parameters).
module tb_pll_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       locked, out_rst_n, timeout_err, fault;
    logic [7:0] lost_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pll_reconfig_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (32),
        .MAX_RETRY    (2),
        .INIT_IDSEL   (6'd0),
        .INIT_FBDSEL  (6'd0),
        .INIT_ODSEL   (6'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idsel   (cfg_idsel),
        .cfg_fbdsel  (cfg_fbdsel),
        .cfg_odsel   (cfg_odsel),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .locked      (locked),
        .out_rst_n   (out_rst_n),
        .timeout_err (timeout_err),
        .fault       (fault),
        .lost_cnt    (lost_cnt)
    );

    always #5 clk = ~clk;

    // Cycle budget guard so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; samples and drives happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // Reset release lands just after an edge, so the next edge is cycle 1.
    task automatic do_reset();
        rst_n      = 1'b0;
        pll_lock   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idsel  = 6'd0;
        cfg_fbdsel = 6'd0;
        cfg_odsel  = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_locked(input logic want, input int budget, input string tag);
        int n = 0;
        while (locked !== want && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(locked), 32'(want));
    endtask

    initial begin
        // Reset values and lock-up timing.
        do_reset();
        check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_out_rst_n", 32'(out_rst_n), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check_eq("rst_sel", {14'd0, pll_idsel, pll_fbdsel, pll_odsel}, 32'd0);
        tick_to(3);
        check_eq("t1_pll_reset_c3", 32'(pll_reset), 32'd1);
        tick_to(4);
        check_eq("t1_pll_reset_c4", 32'(pll_reset), 32'd0);
        tick_to(9);
        pll_lock = 1'b1;
        check_eq("t1_ready_wait", 32'(cfg_ready), 32'd0);
        tick_to(19);
        check_eq("t1_locked_c19", 32'(locked), 32'd0);
        tick_to(20);
        check_eq("t1_locked_c20", 32'(locked), 32'd1);
        check_eq("t1_outrst_c20", 32'(out_rst_n), 32'd0);
        check_eq("t1_ready_run", 32'(cfg_ready), 32'd1);
        tick_to(21);
        check_eq("t1_outrst_c21", 32'(out_rst_n), 32'd1);

        // One-cycle lock glitch at stable count 5 restarts the window.
        do_reset();
        tick_to(9);
        pll_lock = 1'b1;
        tick_to(17);
        pll_lock = 1'b0;
        tick_to(18);
        pll_lock = 1'b1;
        tick_to(20);
        check_eq("t2_locked_c20", 32'(locked), 32'd0);
        tick_to(28);
        check_eq("t2_locked_c28", 32'(locked), 32'd0);
        check_eq("t2_pll_reset", 32'(pll_reset), 32'd0);
        tick_to(29);
        check_eq("t2_locked_c29", 32'(locked), 32'd1);

        // Two timeouts lead to FAULT; a config clears it.
        do_reset();
        tick_to(35);
        check_eq("t3_pll_reset_c35", 32'(pll_reset), 32'd0);
        check_eq("t3_terr_c35", 32'(timeout_err), 32'd0);
        tick_to(36);
        check_eq("t3_pll_reset_c36", 32'(pll_reset), 32'd1);
        check_eq("t3_terr_c36", 32'(timeout_err), 32'd1);
        check_eq("t3_fault_c36", 32'(fault), 32'd0);
        tick_to(40);
        check_eq("t3_pll_reset_c40", 32'(pll_reset), 32'd0);
        check_eq("t3_terr_sticky", 32'(timeout_err), 32'd1);
        tick_to(71);
        check_eq("t3_fault_c71", 32'(fault), 32'd0);
        tick_to(72);
        check_eq("t3_fault_c72", 32'(fault), 32'd1);
        check_eq("t3_pll_reset_c72", 32'(pll_reset), 32'd1);
        check_eq("t3_ready_fault", 32'(cfg_ready), 32'd1);
        tick_to(80);
        check_eq("t3_fault_hold", 32'(fault), 32'd1);
        check_eq("t3_pll_reset_hold", 32'(pll_reset), 32'd1);
        cfg_valid = 1'b1;
        cfg_idsel = 6'h3C;
        tick_to(81);
        cfg_valid = 1'b0;
        check_eq("t3_idsel", 32'(pll_idsel), 32'h3C);
        check_eq("t3_fault_clr", 32'(fault), 32'd0);
        check_eq("t3_terr_clr", 32'(timeout_err), 32'd0);
        check_eq("t3_pll_reset_c81", 32'(pll_reset), 32'd1);
        tick_to(84);
        check_eq("t3_pll_reset_c84", 32'(pll_reset), 32'd1);
        tick_to(85);
        check_eq("t3_pll_reset_c85", 32'(pll_reset), 32'd0);

        // Config in RUN, ignored config in WAIT_LOCK, simultaneous loss+config,
        // then async reset during STABLE_CHECK.
        do_reset();
        tick_to(9);
        pll_lock = 1'b1;
        tick_to(22);
        cfg_valid  = 1'b1;
        cfg_fbdsel = 6'h2A;
        pll_lock   = 1'b0;
        check_eq("t4_ready_run", 32'(cfg_ready), 32'd1);
        tick_to(23);
        cfg_valid = 1'b0;
        check_eq("t4_fbdsel", 32'(pll_fbdsel), 32'h2A);
        check_eq("t4_locked_c23", 32'(locked), 32'd0);
        check_eq("t4_outrst_c23", 32'(out_rst_n), 32'd1);
        check_eq("t4_pll_reset_c23", 32'(pll_reset), 32'd1);
        tick_to(24);
        check_eq("t4_outrst_c24", 32'(out_rst_n), 32'd0);
        check_eq("t4_lost_none", 32'(lost_cnt), 32'd0);
        tick_to(27);
        check_eq("t4_pll_reset_c27", 32'(pll_reset), 32'd0);
        cfg_valid  = 1'b1;
        cfg_fbdsel = 6'h15;
        check_eq("t4_ready_wait", 32'(cfg_ready), 32'd0);
        tick_to(28);
        cfg_valid = 1'b0;
        check_eq("t4_fbdsel_kept", 32'(pll_fbdsel), 32'h2A);
        check_eq("t4_pll_reset_c28", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        tick_to(39);
        check_eq("t4_locked_c39", 32'(locked), 32'd1);
        tick_to(40);
        pll_lock = 1'b0;
        tick_to(42);
        cfg_valid  = 1'b1;
        cfg_fbdsel = 6'h2A;
        cfg_odsel  = 6'h11;
        check_eq("t4_locked_c42", 32'(locked), 32'd1);
        tick_to(43);
        cfg_valid = 1'b0;
        check_eq("t4_odsel", 32'(pll_odsel), 32'h11);
        check_eq("t4_lost_both", 32'(lost_cnt), 32'd1);
        check_eq("t4_locked_c43", 32'(locked), 32'd0);
        pll_lock = 1'b1;
        tick_to(50);
        check_eq("t4_stable_pll_reset", 32'(pll_reset), 32'd0);
        check_eq("t4_stable_locked", 32'(locked), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t4_arst_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("t4_arst_sel", {14'd0, pll_idsel, pll_fbdsel, pll_odsel}, 32'd0);
        check_eq("t4_arst_lost", 32'(lost_cnt), 32'd0);
        check_eq("t4_arst_flags",
                 {28'd0, locked, out_rst_n, timeout_err, fault}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        tick_to(3);
        check_eq("t4_repulse_c3", 32'(pll_reset), 32'd1);
        tick_to(4);
        check_eq("t4_repulse_c4", 32'(pll_reset), 32'd0);

        // Lock loss in RUN, repeated until the loss counter saturates.
        do_reset();
        tick_to(9);
        pll_lock = 1'b1;
        tick_to(21);
        check_eq("t5_locked_c21", 32'(locked), 32'd1);
        pll_lock = 1'b0;
        tick_to(23);
        check_eq("t5_locked_c23", 32'(locked), 32'd1);
        tick_to(24);
        check_eq("t5_locked_c24", 32'(locked), 32'd0);
        check_eq("t5_lost_1", 32'(lost_cnt), 32'd1);
        for (int i = 2; i <= 300; i++) begin
            pll_lock = 1'b1;
            wait_locked(1'b1, 100, "t5_relock");
            pll_lock = 1'b0;
            wait_locked(1'b0, 10, "t5_loss");
            if (i == 254) check_eq("t5_lost_254", 32'(lost_cnt), 32'd254);
        end
        check_eq("t5_lost_sat", 32'(lost_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
